// File: rtl/icw_sequencer_if.sv
// Write-strobe/data bundle from the 8259A bus and read-write decoder into the ICW sequencer.
interface icw_sequencer_if;
    logic       write_initial_command_word_1;
    logic       write_odd_address;
    logic [7:0] internal_data_bus;

    modport master (
        output write_initial_command_word_1,
        output write_odd_address,
        output internal_data_bus
    );

    modport slave (
        input  write_initial_command_word_1,
        input  write_odd_address,
        input  internal_data_bus
    );
endinterface

// File: rtl/icw_sequencer.sv
// 8259A initialization-command-word sequencer: captures ICW1..ICW4, then forwards odd writes as OCW1.
// Optional macro ICW_CASCADE_EN enables the ICW3 step and cascade outputs.
module icw_sequencer #(
    parameter int CASCADE_LINES    = 8,
    parameter int CASCADE_ID_WIDTH = 3
) (
    input  logic                        clock,
    input  logic                        reset_n,
    icw_sequencer_if.slave              bus,
    output logic [10:0]                 interrupt_vector_address,
    output logic                        level_or_edge_triggered_config,
    output logic                        call_address_interval_4_or_8_config,
    output logic                        single_or_cascade_config,
    output logic                        set_icw4_config,
    output logic [CASCADE_LINES-1:0]    cascade_device_config,
    output logic [CASCADE_ID_WIDTH-1:0] slave_id,
    output logic                        microprocessor_mode_config,
    output logic                        auto_eoi_config,
    output logic                        buffered_mode_config,
    output logic                        buffered_master_or_slave_config,
    output logic                        special_fully_nested_config,
    output logic                        initialization_clear,
    output logic                        initialization_done,
    output logic                        write_operation_control_word_1
);

    typedef enum logic [2:0] {
        IDLE,
        EXPECT_ICW2,
`ifdef ICW_CASCADE_EN
        EXPECT_ICW3,
`endif
        EXPECT_ICW4,
        READY
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] vec_hi_q, vec_hi_d;
    logic [2:0] vec_lo_q, vec_lo_d;
    logic       ltim_q, ltim_d;
    logic       adi_q, adi_d;
    logic       ic4_q, ic4_d;
    logic       upm_q, upm_d;
    logic       aeoi_q, aeoi_d;
    logic       ms_q, ms_d;
    logic       buf_q, buf_d;
    logic       sfnm_q, sfnm_d;
    logic       clr_q, clr_d;
    logic       ocw1_q, ocw1_d;
`ifdef ICW_CASCADE_EN
    logic                     sngl_q, sngl_d;
    logic [CASCADE_LINES-1:0] casc_q, casc_d;
`endif

    logic [7:0] data;
    assign data = bus.internal_data_bus;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            vec_hi_q <= '0;
            vec_lo_q <= '0;
            ltim_q   <= 1'b0;
            adi_q    <= 1'b0;
            ic4_q    <= 1'b0;
            upm_q    <= 1'b0;
            aeoi_q   <= 1'b0;
            ms_q     <= 1'b0;
            buf_q    <= 1'b0;
            sfnm_q   <= 1'b0;
            clr_q    <= 1'b0;
            ocw1_q   <= 1'b0;
`ifdef ICW_CASCADE_EN
            sngl_q   <= 1'b0;
            casc_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            vec_hi_q <= vec_hi_d;
            vec_lo_q <= vec_lo_d;
            ltim_q   <= ltim_d;
            adi_q    <= adi_d;
            ic4_q    <= ic4_d;
            upm_q    <= upm_d;
            aeoi_q   <= aeoi_d;
            ms_q     <= ms_d;
            buf_q    <= buf_d;
            sfnm_q   <= sfnm_d;
            clr_q    <= clr_d;
            ocw1_q   <= ocw1_d;
`ifdef ICW_CASCADE_EN
            sngl_q   <= sngl_d;
            casc_q   <= casc_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_hi_d = vec_hi_q;
        vec_lo_d = vec_lo_q;
        ltim_d   = ltim_q;
        adi_d    = adi_q;
        ic4_d    = ic4_q;
        upm_d    = upm_q;
        aeoi_d   = aeoi_q;
        ms_d     = ms_q;
        buf_d    = buf_q;
        sfnm_d   = sfnm_q;
        clr_d    = 1'b0;
        ocw1_d   = 1'b0;
`ifdef ICW_CASCADE_EN
        sngl_d   = sngl_q;
        casc_d   = casc_q;
`endif
        // ICW1 takes priority over a simultaneous odd write, which is dropped.
        if (bus.write_initial_command_word_1) begin
            vec_lo_d = data[7:5];
            ltim_d   = data[3];
            adi_d    = data[2];
            ic4_d    = data[0];
            vec_hi_d = '0;
            upm_d    = 1'b0;
            aeoi_d   = 1'b0;
            ms_d     = 1'b0;
            buf_d    = 1'b0;
            sfnm_d   = 1'b0;
            clr_d    = 1'b1;
            state_d  = EXPECT_ICW2;
`ifdef ICW_CASCADE_EN
            sngl_d   = data[1];
            casc_d   = '0;
`endif
        end else if (bus.write_odd_address) begin
            case (state_q)
                EXPECT_ICW2: begin
                    vec_hi_d = data;
`ifdef ICW_CASCADE_EN
                    if (!sngl_q)
                        state_d = EXPECT_ICW3;
                    else
`endif
                    if (ic4_q)
                        state_d = EXPECT_ICW4;
                    else
                        state_d = READY;
                end
`ifdef ICW_CASCADE_EN
                EXPECT_ICW3: begin
                    casc_d  = CASCADE_LINES'(data);
                    state_d = ic4_q ? EXPECT_ICW4 : READY;
                end
`endif
                EXPECT_ICW4: begin
                    upm_d   = data[0];
                    aeoi_d  = data[1];
                    ms_d    = data[2];
                    buf_d   = data[3];
                    sfnm_d  = data[4];
                    state_d = READY;
                end
                READY:   ocw1_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign interrupt_vector_address            = {vec_hi_q, vec_lo_q};
    assign level_or_edge_triggered_config      = ltim_q;
    assign call_address_interval_4_or_8_config = adi_q;
    assign set_icw4_config                     = ic4_q;
    assign microprocessor_mode_config          = upm_q;
    assign auto_eoi_config                     = aeoi_q;
    assign buffered_master_or_slave_config     = ms_q;
    assign buffered_mode_config                = buf_q;
    assign special_fully_nested_config         = sfnm_q;
    assign initialization_clear                = clr_q;
    assign initialization_done                 = (state_q == READY);
    assign write_operation_control_word_1      = ocw1_q;
`ifdef ICW_CASCADE_EN
    assign single_or_cascade_config            = sngl_q;
    assign cascade_device_config               = casc_q;
    assign slave_id                            = casc_q[CASCADE_ID_WIDTH-1:0];
`else
    assign single_or_cascade_config            = 1'b1;
    assign cascade_device_config               = '0;
    assign slave_id                            = '0;
`endif

endmodule

// File: tb/tb_icw_sequencer.sv
// Scoreboard bench for icw_sequencer: driver queues expected output snapshots, monitor compares at negedge.
module tb_icw_sequencer;

`ifdef ICW_CASCADE_EN
    localparam bit CASC = 1'b1;
`else
    localparam bit CASC = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] vec;
        logic        ltim, adi, sngl, ic4;
        logic [7:0]  casc;
        logic [2:0]  sid;
        logic        upm, aeoi, bufm, ms, sfnm;
        logic        clr, done, ocw1;
    } out_t;

    logic clock;
    logic reset_n;

    logic [10:0] vec;
    logic        ltim, adi, sngl, ic4;
    logic [7:0]  casc;
    logic [2:0]  sid;
    logic        upm, aeoi, bufm, ms, sfnm, clr, done, ocw1;

    icw_sequencer_if bus ();

    icw_sequencer #(
        .CASCADE_LINES    (8),
        .CASCADE_ID_WIDTH (3)
    ) dut (
        .clock                               (clock),
        .reset_n                             (reset_n),
        .bus                                 (bus.slave),
        .interrupt_vector_address            (vec),
        .level_or_edge_triggered_config      (ltim),
        .call_address_interval_4_or_8_config (adi),
        .single_or_cascade_config            (sngl),
        .set_icw4_config                     (ic4),
        .cascade_device_config               (casc),
        .slave_id                            (sid),
        .microprocessor_mode_config          (upm),
        .auto_eoi_config                     (aeoi),
        .buffered_mode_config                (bufm),
        .buffered_master_or_slave_config     (ms),
        .special_fully_nested_config         (sfnm),
        .initialization_clear                (clr),
        .initialization_done                 (done),
        .write_operation_control_word_1      (ocw1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    out_t q[$];
    out_t e;

    function automatic out_t snap();
        out_t s;
        s.vec = vec;   s.ltim = ltim; s.adi = adi;   s.sngl = sngl; s.ic4 = ic4;
        s.casc = casc; s.sid = sid;   s.upm = upm;   s.aeoi = aeoi; s.bufm = bufm;
        s.ms = ms;     s.sfnm = sfnm; s.clr = clr;   s.done = done; s.ocw1 = ocw1;
        return s;
    endfunction

    task automatic compare(input string name, input out_t exp);
        out_t act;
        act = snap();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (vec=%h casc=%h clr=%b done=%b ocw1=%b)",
                     name, act, exp, act.vec, act.casc, act.clr, act.done, act.ocw1);
        end
    endtask

    // Monitor: every queued snapshot is due on the negedge after its strobe edge.
    initial begin
        out_t exp;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                exp = q.pop_front();
                compare("seq", exp);
            end
        end
    end

    function automatic out_t reset_val();
        out_t r;
        r = '0;
        r.sngl = !CASC;
        return r;
    endfunction

    task automatic push_e();
        q.push_back(e);
        e.clr  = 1'b0;
        e.ocw1 = 1'b0;
    endtask

    task automatic wr(input logic icw1, input logic odd, input logic [7:0] d);
        @(negedge clock);
        bus.write_initial_command_word_1 = icw1;
        bus.write_odd_address            = odd;
        bus.internal_data_bus            = d;
        @(posedge clock);
        #1;
        bus.write_initial_command_word_1 = 1'b0;
        bus.write_odd_address            = 1'b0;
        bus.internal_data_bus            = 8'h00;
        push_e();
    endtask

    task automatic idle();
        @(negedge clock);
        @(posedge clock);
        #1;
        push_e();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.write_initial_command_word_1 = 1'b0;
        bus.write_odd_address            = 1'b0;
        bus.internal_data_bus            = 8'h00;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1 compare("reset_init", reset_val());
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        e = reset_val();

        // Odd write in IDLE is ignored.
        wr(1'b0, 1'b1, 8'hAA);

        // T1: reset mid-sequence (EXPECT_ICW3 with cascade, EXPECT_ICW4 otherwise).
        e.clr = 1'b1; e.ic4 = 1'b1; e.sngl = !CASC;
        wr(1'b1, 1'b0, 8'h11);
        e.vec = 11'h040;
        wr(1'b0, 1'b1, 8'h08);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 compare("t1_async_reset", reset_val());
        @(negedge clock);
        reset_n = 1'b1;
        e = reset_val();
        wr(1'b0, 1'b1, 8'h55);

        // T2: single mode, ICW3 skipped.
        e.clr = 1'b1; e.sngl = 1'b1; e.ic4 = 1'b1;
        wr(1'b1, 1'b0, 8'h13);
        e.vec = 11'h100;
        wr(1'b0, 1'b1, 8'h20);
        e.upm = 1'b1; e.aeoi = 1'b1; e.done = 1'b1;
        wr(1'b0, 1'b1, 8'h03);
        e.ocw1 = 1'b1;
        wr(1'b0, 1'b1, 8'h55);
        idle();

        // T3: cascade mode with ICW3 (ICW3 write only exists with cascade).
        e = reset_val(); e.clr = 1'b1; e.ic4 = 1'b1;
        wr(1'b1, 1'b0, 8'h11);
        e.vec = 11'h040;
        wr(1'b0, 1'b1, 8'h08);
`ifdef ICW_CASCADE_EN
        e.casc = 8'h04; e.sid = 3'd4;
        wr(1'b0, 1'b1, 8'h04);
`endif
        e.upm = 1'b1; e.done = 1'b1;
        wr(1'b0, 1'b1, 8'h01);

        // T4: IC4=0 goes READY after ICW2, then one OCW1 pulse.
        e = reset_val(); e.clr = 1'b1; e.sngl = 1'b1; e.adi = 1'b0;
        wr(1'b1, 1'b0, 8'h12);
        e.vec = 11'h200; e.done = 1'b1;
        wr(1'b0, 1'b1, 8'h40);
        e.ocw1 = 1'b1;
        wr(1'b0, 1'b1, 8'hFF);
        idle();

        // T6: both strobes in READY, ICW1 wins.
        e = reset_val(); e.clr = 1'b1; e.vec = 11'h007; e.adi = 1'b1;
        wr(1'b1, 1'b1, 8'hE4);
        idle();

        // T5: restart mid-sequence, then back-to-back completion with ICW4=0xFF.
        e = reset_val(); e.clr = 1'b1; e.ltim = 1'b1; e.adi = 1'b1; e.sngl = 1'b1; e.ic4 = 1'b1;
        wr(1'b1, 1'b0, 8'h1F);
        e.vec = 11'h558;
        wr(1'b0, 1'b1, 8'hAB);
        e = reset_val(); e.clr = 1'b1; e.sngl = 1'b1; e.ic4 = 1'b1;
        wr(1'b1, 1'b0, 8'h13);
        e.vec = 11'h100;
        wr(1'b0, 1'b1, 8'h20);
        e.upm = 1'b1; e.aeoi = 1'b1; e.ms = 1'b1; e.bufm = 1'b1; e.sfnm = 1'b1; e.done = 1'b1;
        wr(1'b0, 1'b1, 8'hFF);

        // Cascade without ICW4: ICW3 completes the sequence; without cascade ICW2 does.
        e = reset_val(); e.clr = 1'b1;
        wr(1'b1, 1'b0, 8'h10);
        e.vec = 11'h008; e.done = !CASC;
        wr(1'b0, 1'b1, 8'h01);
`ifdef ICW_CASCADE_EN
        e.casc = 8'h80; e.sid = 3'd0; e.done = 1'b1;
`else
        e.ocw1 = 1'b1;
`endif
        wr(1'b0, 1'b1, 8'h80);
        idle();

        @(negedge clock);
        @(negedge clock);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
